// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout and counter width for the injection arbiter.
package noc_pkg;

  localparam int FLIT_W    = 32;
  localparam int DEST_W    = 8;
  localparam int PAYLOAD_W = 24;
  localparam int CNT_W     = 16;

  typedef struct packed {
    logic [DEST_W-1:0]    dest;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  // Round-robin candidate: the source `step` places after `last`, modulo n.
  function automatic int rr_index(int last, int step, int n);
    return (last + step) % n;
  endfunction

endpackage

// File: rtl/inj_fifo.sv
// Single-clock synchronous FIFO for one injection source; no write-to-read bypass.
module inj_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/noc_inject_arbiter.sv
// Round-robin arbiter draining NUM_REQ source FIFOs into one registered NoC injection port.
// Optional per-source delivered-flit counters are built when INJ_STATS_EN is defined.
module noc_inject_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = FLIT_W,
  localparam int GW = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic [DATA_W-1:0]         o_data,
  output logic                      o_data_valid,
  input  logic                      i_data_ready,
  output logic [GW-1:0]             o_grant_id,
  output logic [NUM_REQ*CNT_W-1:0]  o_pkt_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_REQ-1:0] fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic [DATA_W-1:0]  fifo_head  [NUM_REQ];
  logic [CW-1:0]      fifo_count [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_src
    // Ready comes from the registered count only, so a full FIFO refuses a push even while popped.
    assign o_req_ready[k] = !rst && (fifo_count[k] != CW'(FIFO_DEPTH));
    assign fifo_push[k]   = i_req_valid[k] && !fifo_full[k] && !rst;

    inj_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push[k]),
      .push_data (i_req_data[k*DATA_W +: DATA_W]),
      .pop       (fifo_pop[k]),
      .head      (fifo_head[k]),
      .count     (fifo_count[k]),
      .empty     (fifo_empty[k]),
      .full      (fifo_full[k])
    );
  end

  logic [DATA_W-1:0] data_q, data_d;
  logic              data_valid_q, data_valid_d;
  logic [GW-1:0]     grant_id_q, grant_id_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;
  logic              grant_found, out_free;
  logic [GW-1:0]     grant_idx, cand;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = GW'(rr_index(int'(last_grant_q), i, NUM_REQ));
      if (!grant_found && !fifo_empty[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    out_free     = !data_valid_q || i_data_ready;
    data_d       = data_q;
    data_valid_d = data_valid_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    fifo_pop     = '0;
    if (out_free) begin
      data_valid_d = grant_found;
      if (grant_found) begin
        data_d              = fifo_head[grant_idx];
        grant_id_d          = grant_idx;
        last_grant_d        = grant_idx;
        fifo_pop[grant_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q       <= '0;
      data_valid_q <= 1'b0;
      grant_id_q   <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
    end else begin
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign o_data       = data_q;
  assign o_data_valid = data_valid_q;
  assign o_grant_id   = grant_id_q;

`ifdef INJ_STATS_EN
  logic [CNT_W-1:0] pkt_cnt_q [NUM_REQ];
  logic [CNT_W-1:0] pkt_cnt_d [NUM_REQ];

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      pkt_cnt_d[k] = pkt_cnt_q[k]
                   + CNT_W'(data_valid_q && i_data_ready && (grant_id_q == GW'(k)));
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_REQ; k++) begin
      if (rst) pkt_cnt_q[k] <= '0;
      else     pkt_cnt_q[k] <= pkt_cnt_d[k];
    end
  end

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_cnt
    assign o_pkt_count[k*CNT_W +: CNT_W] = pkt_cnt_q[k];
  end
`else
  assign o_pkt_count = '0;
`endif

endmodule

// File: doc/noc_inject_arbiter.md
# noc_inject_arbiter

Shares one NoC router injection port between `NUM_REQ` local packet sources, for example several traffic generators or PE sub-units behind one router port. Each source has a small FIFO. A round-robin arbiter drains the FIFOs into a single registered valid/ready output carrying 32-bit flits. Flit format is `{dest[7:0], payload[23:0]}`, passed through unmodified. The block sits between the PE-side sources and the router's `i_data`/`i_data_valid`/`o_data_ready` port.

## Interface
- `NUM_REQ`, default 4: number of sources, 2..16.
- `FIFO_DEPTH`, default 4: entries per source FIFO; power of two, ≥2.
- `DATA_W`, default 32: flit width; dest is bits `[DATA_W-1:DATA_W-8]`.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_req_data`  in  NUM_REQ*DATA_W  source k flit at `[k*DATA_W +: DATA_W]`.
- `i_req_valid`  in  NUM_REQ  source k flit valid.
- `o_req_ready`  out  NUM_REQ  source k FIFO not full.
- `o_data`  out  DATA_W  flit to router.
- `o_data_valid`  out  1  flit valid.
- `i_data_ready`  in  1  router accepts the flit.
- `o_grant_id`  out  $clog2(NUM_REQ)  source index of the current `o_data`.
- `o_pkt_count`  out  NUM_REQ*16  per-source delivered-flit counters; see Configuration.

## Operation
- **Push.** Source k pushes at an edge where `i_req_valid[k] & o_req_ready[k]`.
  - `o_req_ready[k] = !rst & (count_k != FIFO_DEPTH)`, derived from the registered count only.
  - A full FIFO therefore refuses a push even in the cycle it is popped.
- **Output register.**
  - Free when `!o_data_valid` or `o_data_valid & i_data_ready`.
  - When free and any FIFO is non-empty, the arbiter grants source g and pops FIFO g in the same edge. It loads `o_data` ← head of g, `o_grant_id` ← g, `o_data_valid` ← 1.
  - When free and all FIFOs are empty, `o_data_valid` ← 0; `o_data` and `o_grant_id` hold their values.
- **Round-robin.**
  - Register `last_grant` resets to `NUM_REQ-1`.
  - Search order is `last_grant+1, +2, …` modulo `NUM_REQ`; the first non-empty FIFO wins.
  - `last_grant` ← g on every grant.
- **Hold rule.** While `o_data_valid & !i_data_ready`, `o_data`, `o_grant_id` and `o_data_valid` are stable and no FIFO is popped.
- **FIFO pointers.** Wrap modulo `FIFO_DEPTH`. A simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- **Empty-FIFO timing.** A FIFO written at edge t is visible to the arbiter from edge t+1; there is no bypass.
- **Reset.** `rst` asserted at any edge, including mid-packet or while stalled, discards all queued and in-flight flits.
- **Reset values.**
  - `o_data_valid` = 0, `o_data` = 0, `o_grant_id` = 0.
  - All FIFOs empty; `last_grant` = `NUM_REQ-1`; `o_pkt_count` = 0.
  - `o_req_ready` = 0 while `rst` is high and all 1s in the first cycle after.

## Timing
- **Latency.** A flit accepted from source k at edge t appears on `o_data` after edge t+1, provided the output register is free at t+1 and k wins arbitration.
- **Throughput.** One flit per cycle while `i_data_ready` is held high and any FIFO is non-empty.
- **Fairness.** With all sources continuously backlogged, grants rotate 0,1,…,NUM_REQ-1. No source waits more than `NUM_REQ-1` grants.
- **Stall.** `i_data_ready` low for n cycles adds n cycles and causes no loss or duplication.
- **Path restriction.** There is no combinational path from `i_req_valid` or `i_data_ready` to any output.

## Configuration
- **`INJ_STATS_EN` defined.**
  - `o_pkt_count[k*16 +: 16]` increments by 1 at each edge where `o_data_valid & i_data_ready & (o_grant_id == k)`.
  - The counter wraps 0xFFFF→0.
- **`INJ_STATS_EN` undefined.** The counters are not built and `o_pkt_count` is tied to 0. The port list is identical either way.

## Structure
- **Shared package `noc_pkg`.**
  - `FLIT_W` = 32, `DEST_W` = 8, `PAYLOAD_W` = 24.
  - Typedef `flit_t` as a packed struct `{dest, payload}`.
  - `CNT_W` = 16.
- **Sub-module `inj_fifo`.** A single-clock synchronous FIFO parameterised by width and depth, exposing `count`, `empty`, `full`, `push`, `pop` and `head`. It is instantiated `NUM_REQ` times.
- **Top level.** Arbiter, `last_grant`, the output register and the optional counters live in `noc_inject_arbiter`.

## Test plan
- **Reset.** Hold `rst` 3 cycles with all `i_req_valid`=1.
  - During reset: `o_req_ready`=0, `o_data_valid`=0, `o_data`=0.
  - First cycle after reset: `o_req_ready`=4'b1111.
- **Single source.** Source 2 pushes 0x05000007 at edge t with `i_data_ready`=1 → `o_data`=0x05000007, `o_grant_id`=2, `o_data_valid`=1 after edge t+1; `o_data_valid`=0 after t+2.
- **Backlog rotation.** All 4 FIFOs preloaded with 2 flits, `i_data_ready`=1 → `o_grant_id` sequence 0,1,2,3,0,1,2,3 on 8 consecutive cycles, then `o_data_valid`=0.
- **Stall and full.**
  - With `i_data_ready`=0, source 1 pushes 5 flits → `o_req_ready[1]`=0 after 4 are in the FIFO.
  - `o_data` holds the first flit unchanged for 10 cycles.
  - Releasing `i_data_ready` delivers all flits in order without loss.
- **Reset mid-flight.** Assert `rst` while `o_data_valid`=1 and FIFOs hold 3 flits → after the reset edge, `o_data_valid`=0 and no queued flit is ever emitted.
- **Stats.** With `INJ_STATS_EN`, deliver 3 flits from source 0 and 1 from source 3 → `o_pkt_count` fields {0:3, 1:0, 2:0, 3:1}. Without the macro, the same stimulus leaves them all 0.
